// File: rtl/score_overlay.sv
// Text overlay for the Tetris side panel: current and highest score as
// decimal digits plus a blinking YOU WIN / YOU LOSE banner. Digits come
// from a sequential double-dabble converter whose result is only shown at
// the next frame_start, so a frame never mixes old and new digits.
module score_overlay #(
    parameter int SCORE_W      = 7,
    parameter int DIGITS       = 3,
    parameter int SCALE        = 2,
    parameter int BANNER_SCALE = 5,
    parameter int BLINK_FRAMES = 30,
    parameter int ORIGIN_X     = 20,
    parameter int SCORE_Y      = 150,
    parameter int HIGH_Y       = 230,
    parameter int BANNER_X     = 450,
    parameter int BANNER_Y     = 120,
    parameter int DIGIT_BASE   = 27
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_start,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic [SCORE_W-1:0] Score,
    input  logic               Clear_High,
    input  logic               Win,
    input  logic               Lose,
    output logic [9:0]         rom_addr,
    input  logic [7:0]         rom_data,
    output logic               Text_On,
    output logic               Busy
);

    localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int CW    = $clog2(SCORE_W + 1);
    localparam int LIMIT = 10 ** DIGITS;
    localparam logic [BW-1:0]       BLINK_LAST = BW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
    localparam logic [CW-1:0]       SHIFT_LAST = CW'(SCORE_W - 1);
    localparam logic [4*DIGITS-1:0] NINES      = {DIGITS{4'h9}};

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT} state_t;

    state_t              state;
    logic [SCORE_W-1:0]  highest;
    logic [SCORE_W-1:0]  snap_s, snap_h, bin_s, bin_h;
    logic [4*DIGITS-1:0] bcd_s, bcd_h, shown_s, shown_h;
    logic [CW-1:0]       cnt;
    logic                phase_vis, act_q;
    logic [BW-1:0]       blink_cnt;
    logic                banner_on;
    logic [9:0]          addr_d;
    logic [2:0]          col_d, col_q;
    logic                hit_d, hit_q;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
    function automatic logic [4*DIGITS-1:0] dabble(input logic [4*DIGITS-1:0] bcd, input logic msb);
        logic [4*DIGITS-1:0] t;
        t = bcd;
        for (int d = 0; d < DIGITS; d++)
            if (t[4*d +: 4] >= 4'd5) t[4*d +: 4] = t[4*d +: 4] + 4'd3;
        return {t[4*DIGITS-2:0], msb};
    endfunction

    // Banner letter for character k of a line; 0 means no character there.
    function automatic int banner_glyph(input logic second, input logic lose, input int k);
        int g;
        g = 0;
        if (!second) begin
            case (k)
                0: g = 25; 1: g = 15; 2: g = 21;
                default: g = 0;
            endcase
        end else if (lose) begin
            case (k)
                0: g = 12; 1: g = 15; 2: g = 19; 3: g = 5;
                default: g = 0;
            endcase
        end else begin
            case (k)
                0: g = 23; 1: g = 9; 2: g = 14;
                default: g = 0;
            endcase
        end
        return g;
    endfunction

    // Highest score tracker; clearing takes precedence over a new maximum.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                highest <= '0;
        else if (Clear_High)      highest <= '0;
        else if (Score > highest) highest <= Score;
    end

    // BCD converter FSM: snapshot, shift SCORE_W cycles, publish on frame_start.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= S_IDLE;
            Busy    <= 1'b0;
            snap_s  <= '0;
            snap_h  <= '0;
            bin_s   <= '0;
            bin_h   <= '0;
            bcd_s   <= '0;
            bcd_h   <= '0;
            cnt     <= '0;
            shown_s <= '0;
            shown_h <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Score != snap_s || highest != snap_h) begin
                        snap_s <= Score;
                        snap_h <= highest;
                        bin_s  <= Score;
                        bin_h  <= highest;
                        bcd_s  <= '0;
                        bcd_h  <= '0;
                        cnt    <= '0;
                        Busy   <= 1'b1;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_s <= dabble(bcd_s, bin_s[SCORE_W-1]);
                    bcd_h <= dabble(bcd_h, bin_h[SCORE_W-1]);
                    bin_s <= bin_s << 1;
                    bin_h <= bin_h << 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == SHIFT_LAST) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (frame_start) begin
                        shown_s <= (int'(snap_s) >= LIMIT) ? NINES : bcd_s;
                        shown_h <= (int'(snap_h) >= LIMIT) ? NINES : bcd_h;
                        Busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Banner blink phase: counts frames, restarts visible when the banner appears.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            phase_vis <= 1'b1;
            blink_cnt <= '0;
            act_q     <= 1'b0;
        end else begin
            act_q <= Win | Lose;
            if ((Win | Lose) && !act_q) begin
                phase_vis <= 1'b1;
                blink_cnt <= '0;
            end else if (BLINK_FRAMES != 0 && frame_start) begin
                if (blink_cnt == BLINK_LAST) begin
                    phase_vis <= ~phase_vis;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    assign banner_on = (Win | Lose) & (phase_vis | (BLINK_FRAMES == 0));

    // Pixel stage 1 (combinational part): region hit, glyph and scaled row/column.
    always_comb begin : pixel_map
        int x, y, sx, row, bx, ly, g;
        logic [3:0] dv;
        logic in_score, in_high, line1, line2;
        x        = int'(DrawX);
        y        = int'(DrawY);
        sx       = 0;
        row      = 0;
        bx       = 0;
        ly       = 0;
        g        = 0;
        dv       = '0;
        addr_d   = '0;
        col_d    = '0;
        hit_d    = 1'b0;
        in_score = (y >= SCORE_Y) && (y < SCORE_Y + 16*SCALE);
        in_high  = (y >= HIGH_Y) && (y < HIGH_Y + 16*SCALE);
        line1    = (y >= BANNER_Y) && (y < BANNER_Y + 16*BANNER_SCALE);
        line2    = (y >= BANNER_Y + 80) && (y < BANNER_Y + 80 + 16*BANNER_SCALE);
        if (x >= ORIGIN_X && x < ORIGIN_X + DIGITS*8*SCALE && (in_score || in_high)) begin
            sx  = (x - ORIGIN_X) / SCALE;
            row = in_score ? (y - SCORE_Y) / SCALE : (y - HIGH_Y) / SCALE;
            for (int d = 0; d < DIGITS; d++)
                if (sx / 8 == d)
                    dv = in_score ? shown_s[4*(DIGITS-1-d) +: 4] : shown_h[4*(DIGITS-1-d) +: 4];
            addr_d = 10'((DIGIT_BASE + int'(dv)) * 16 + row);
            col_d  = 3'(sx);
            hit_d  = 1'b1;
        end else if (banner_on && x >= BANNER_X && (line1 || line2)) begin
            bx = (x - BANNER_X) / BANNER_SCALE;
            ly = line1 ? (y - BANNER_Y) / BANNER_SCALE : (y - BANNER_Y - 80) / BANNER_SCALE;
            g  = banner_glyph(line2, Lose, bx / 10);
            if (bx % 10 < 8 && g != 0) begin
                addr_d = 10'(g * 16 + ly);
                col_d  = 3'(bx % 10);
                hit_d  = 1'b1;
            end
        end
    end

    // Pixel stages 1 and 2: register ROM address, then pick the lit bit from the ROM row.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr <= '0;
            col_q    <= '0;
            hit_q    <= 1'b0;
            Text_On  <= 1'b0;
        end else begin
            rom_addr <= addr_d;
            col_q    <= col_d;
            hit_q    <= hit_d;
            Text_On  <= hit_q & rom_data[3'd7 - col_q];
        end
    end

endmodule

// File: tb/tb_score_overlay.sv
// Directed bench for score_overlay: a 3-digit instance and a 2-digit
// instance share stimulus; expected ROM addresses are hand-computed glyph rows.
module tb_score_overlay;

    logic       Clk, Reset, frame_start, Clear_High, Win, Lose;
    logic [9:0] DrawX, DrawY;
    logic [6:0] Score;
    logic [9:0] rom_addr, rom_addr2;
    logic [7:0] rom_data, rom_data2;
    logic       Text_On, Text_On2, Busy, Busy2;

    int tests_run    = 0;
    int tests_failed = 0;

    // Stand-in alphabet ROM: every row pattern is a simple function of its address.
    function automatic logic [7:0] rom_fn(input logic [9:0] a);
        return ~a[7:0];
    endfunction

    assign rom_data  = rom_fn(rom_addr);
    assign rom_data2 = rom_fn(rom_addr2);

    score_overlay #(.BLINK_FRAMES(2)) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .Score(Score), .Clear_High(Clear_High),
        .Win(Win), .Lose(Lose), .rom_addr(rom_addr), .rom_data(rom_data),
        .Text_On(Text_On), .Busy(Busy)
    );

    score_overlay #(.DIGITS(2), .BLINK_FRAMES(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .Score(Score), .Clear_High(Clear_High),
        .Win(Win), .Lose(Lose), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .Text_On(Text_On2), .Busy(Busy2)
    );

    // Clock and reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic pulse_frame();
        @(negedge Clk);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
    endtask

    // Drive one pixel; check rom_addr one cycle later and Text_On one cycle after that.
    task automatic px(input string tag, input int which, input int x, input int y,
                      input int col, input logic [9:0] exp_addr);
        logic [7:0] r;
        logic       exp_on;
        @(negedge Clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(negedge Clk);
        check({tag, "_addr"}, (which != 0) ? rom_addr2 : rom_addr, exp_addr);
        r      = rom_fn(exp_addr);
        exp_on = (exp_addr != 10'd0) ? r[7-col] : 1'b0;
        @(negedge Clk);
        check({tag, "_on"}, (which != 0) ? Text_On2 : Text_On, exp_on);
    endtask

    initial begin
        Reset = 1'b1; frame_start = 1'b0; Clear_High = 1'b0; Win = 1'b0; Lose = 1'b0;
        DrawX = '0; DrawY = '0; Score = '0;
        wait_cycles(3);
        check("rst_busy", Busy, 1'b0);
        check("rst_addr", rom_addr, 10'd0);
        check("rst_text", Text_On, 1'b0);
        Reset = 1'b0;

        // Score 0 after reset: '0' glyphs on both rows, no conversion, no banner
        wait_cycles(4);
        check("idle_busy", Busy, 1'b0);
        px("s0_d0c0", 0, 20, 150, 0, 10'd432);
        px("s0_d0c1", 0, 22, 150, 1, 10'd432);
        px("s0_d2r3", 0, 55, 156, 1, 10'd435);
        px("h0_d0r5", 0, 20, 240, 0, 10'd437);
        px("outside", 0, 5, 5, 0, 10'd0);
        px("no_banner", 0, 455, 120, 1, 10'd0);

        // Score 0 -> 57: frame_start during the last shift cycle is ignored
        Score = 7'd57;
        @(negedge Clk);
        check("busy_rise", Busy, 1'b1);
        wait_cycles(6);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        check("busy_last_shift", Busy, 1'b1);
        px("hold_000", 0, 52, 150, 0, 10'd432);
        pulse_frame();
        check("busy_fall", Busy, 1'b0);
        px("s57_d0", 0, 20, 150, 0, 10'd432);
        px("s57_d1", 0, 36, 150, 0, 10'd512);
        px("s57_d2", 0, 52, 150, 0, 10'd544);
        px("h_pending", 0, 36, 230, 0, 10'd432);
        wait_cycles(4);
        pulse_frame();
        px("h57_d1", 0, 36, 230, 0, 10'd512);
        px("h57_d2", 0, 52, 230, 0, 10'd544);

        // Score drops to 42: highest keeps 57; clear then re-track to 42
        Score = 7'd42;
        wait_cycles(12);
        pulse_frame();
        px("s42_d1", 0, 36, 150, 0, 10'd496);
        px("h_keep57", 0, 36, 230, 0, 10'd512);
        @(negedge Clk);
        Clear_High = 1'b1;
        @(negedge Clk);
        Clear_High = 1'b0;
        wait_cycles(12);
        pulse_frame();
        px("h_cleared", 0, 36, 230, 0, 10'd432);
        wait_cycles(12);
        pulse_frame();
        px("h42_d1", 0, 36, 230, 0, 10'd496);
        px("h42_d2", 0, 52, 230, 0, 10'd464);

        // Score 120: three digits show 120, two digits saturate to 99
        Score = 7'd120;
        wait_cycles(12);
        pulse_frame();
        wait_cycles(12);
        pulse_frame();
        px("s120_d0", 0, 20, 150, 0, 10'd448);
        px("s120_d1", 0, 36, 150, 0, 10'd464);
        px("s120_d2", 0, 52, 150, 0, 10'd432);
        px("h120_d0", 0, 20, 230, 0, 10'd448);
        px("sat_d0", 1, 20, 150, 0, 10'd576);
        px("sat_d1", 1, 36, 150, 0, 10'd576);
        px("sat_edge", 1, 52, 150, 0, 10'd0);
        px("sat_high", 1, 36, 230, 0, 10'd576);

        // Reset in the middle of a conversion returns shown digits to zero
        Score = 7'd99;
        wait_cycles(3);
        Reset = 1'b1;
        @(negedge Clk);
        check("midrst_busy", Busy, 1'b0);
        check("midrst_addr", rom_addr, 10'd0);
        Reset = 1'b0;
        px("midrst_d0", 0, 20, 150, 0, 10'd432);
        wait_cycles(12);
        pulse_frame();
        px("s99_d1", 0, 36, 150, 0, 10'd576);

        // Banner: YOU LOSE, blink two frames on / two off, LOSE wins over WIN
        Lose = 1'b1;
        px("ban_y", 0, 455, 120, 1, 10'd400);
        px("ban_y_r2", 0, 465, 130, 3, 10'd402);
        px("ban_l", 0, 450, 200, 0, 10'd192);
        px("ban_e", 0, 600, 200, 0, 10'd80);
        px("ban_gap", 0, 490, 120, 0, 10'd0);
        pulse_frame();
        px("blink_f1", 0, 455, 120, 1, 10'd400);
        pulse_frame();
        px("blink_dark1", 0, 455, 120, 1, 10'd0);
        pulse_frame();
        px("blink_dark2", 0, 455, 120, 1, 10'd0);
        pulse_frame();
        px("blink_lit2", 0, 455, 120, 1, 10'd400);
        Win = 1'b1;
        px("lose_prio", 0, 500, 200, 0, 10'd240);
        px("lose_prio_e", 0, 600, 200, 0, 10'd80);
        Lose = 1'b0;
        px("win_i", 0, 500, 200, 0, 10'd144);
        px("win_no4th", 0, 600, 200, 0, 10'd0);
        Win = 1'b0;
        px("ban_off", 0, 455, 120, 1, 10'd0);

        // A fresh banner is forced visible even when the phase was dark
        Win = 1'b1;
        pulse_frame();
        pulse_frame();
        px("forced_dark", 0, 455, 120, 1, 10'd0);
        Win = 1'b0;
        @(negedge Clk);
        Win = 1'b1;
        px("rise_vis", 0, 455, 120, 1, 10'd400);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
